// File: rtl/hdmi_period_sequencer_if.sv
// Timing/period bundle between the HDMI period sequencer and the TMDS/TERC4 encoder muxes.
// The sequencer drives coordinates, syncs and mode; the packet source drives pkt_req.
interface hdmi_period_sequencer_if #(
  parameter int CORDW = 12
);
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [2:0]       mode;
  logic [3:0]       ctl;
  logic             frame_start;
  logic             pkt_req;
  logic             pkt_ack;
  logic [4:0]       pkt_idx;

  modport master (
    output sx, sy, hsync, vsync, de, mode, ctl, frame_start, pkt_ack, pkt_idx,
    input  pkt_req
  );

  modport slave (
    input  sx, sy, hsync, vsync, de, mode, ctl, frame_start, pkt_ack, pkt_idx,
    output pkt_req
  );
endinterface

// File: rtl/hdmi_period_sequencer.sv
// HDMI/DVI raster timing with TMDS period sequencing (control, preamble, guard, video, island).
// Define HDMI_DATA_ISLAND_EN to compile in the data-island scheduler; otherwise pkt_req is ignored.
//
// state    | meaning (island scheduler)
// DI_IDLE  | no island pending on the current line
// DI_ARMED | pkt_req seen at sx==H_ACTIVE-1; island runs from H_ACTIVE+4 to its trailing guard
module hdmi_period_sequencer #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int CORDW      = 12,
  parameter int DI_PACKETS = 1
) (
  input  logic                    clk_pix,
  input  logic                    rst_in,
  hdmi_period_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    M_CTRL   = 3'd0,
    M_VIDEO  = 3'd1,
    M_VGUARD = 3'd2,
    M_ISLAND = 3'd3,
    M_IGUARD = 3'd4,
    M_VPRE   = 3'd5,
    M_IPRE   = 3'd6
  } mode_e;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] HA        = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] H_LAST    = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] HS_BEG    = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END    = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VPRE_BEG  = CORDW'(H_TOTAL - 10);
  localparam logic [CORDW-1:0] VGRD_BEG  = CORDW'(H_TOTAL - 2);
  localparam logic [CORDW-1:0] VA        = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] V_PRELAST = CORDW'(V_ACTIVE - 1);
  localparam logic [CORDW-1:0] V_LAST    = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] VS_BEG    = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END    = CORDW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             H_ON      = 1'(H_POL);
  localparam logic             V_ON      = 1'(V_POL);

  // Blanking must hold at least 12 CTRL + 8 preamble + 2 guard pixels.
  if (H_FP + H_SYNC + H_BP < 22) begin : g_blank_chk
    $error("hdmi_period_sequencer: horizontal blanking shorter than 22 pixels");
  end

  logic             run;
  logic [CORDW-1:0] sx, sy;
  logic [CORDW-1:0] sx_nxt, sy_nxt;
  logic             hsync_q, vsync_q, de_q, fs_q, ack_q;
  logic             hsync_nxt, vsync_nxt, de_nxt, fs_nxt, ack_nxt;
  logic             vid_line;
  mode_e            mode_q, mode_nxt;
  logic [3:0]       ctl_q, ctl_nxt;
  logic [4:0]       idx_q, idx_nxt;
  mode_e            di_mode;
  logic [4:0]       di_idx;

  // The first edge after reset only presents (0,0); counting starts on the next one.
  always_comb begin
    sx_nxt = '0;
    sy_nxt = '0;
    if (run) begin
      if (sx == H_LAST) begin
        sx_nxt = '0;
        sy_nxt = (sy == V_LAST) ? '0 : sy + CORDW'(1);
      end else begin
        sx_nxt = sx + CORDW'(1);
        sy_nxt = sy;
      end
    end
  end

  always_comb begin
    hsync_nxt = ((sx_nxt >= HS_BEG) && (sx_nxt < HS_END)) ? H_ON : ~H_ON;
    vsync_nxt = ((sy_nxt >= VS_BEG) && (sy_nxt < VS_END)) ? V_ON : ~V_ON;
    de_nxt    = (sx_nxt < HA) && (sy_nxt < VA);
    fs_nxt    = (sx_nxt == '0) && (sy_nxt == '0);
    vid_line  = (sy_nxt < V_PRELAST) || (sy_nxt == V_LAST);
    mode_nxt  = M_CTRL;
    ctl_nxt   = 4'b0000;
    ack_nxt   = 1'b0;
    idx_nxt   = '0;
    if (de_nxt) begin
      mode_nxt = M_VIDEO;
    end else if (vid_line && (sx_nxt >= VGRD_BEG)) begin
      mode_nxt = M_VGUARD;
    end else if (vid_line && (sx_nxt >= VPRE_BEG)) begin
      mode_nxt = M_VPRE;
      ctl_nxt  = 4'b0001;
    end else if (di_mode != M_CTRL) begin
      mode_nxt = di_mode;
      idx_nxt  = di_idx;
      ack_nxt  = (di_mode == M_ISLAND) && (di_idx == 5'd0);
      if (di_mode == M_IPRE) ctl_nxt = 4'b0101;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_in) begin
    if (!rst_in) begin
      run     <= 1'b0;
      sx      <= '0;
      sy      <= '0;
      hsync_q <= ~H_ON;
      vsync_q <= ~V_ON;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      mode_q  <= M_CTRL;
      ctl_q   <= 4'b0000;
      ack_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      run     <= 1'b1;
      sx      <= sx_nxt;
      sy      <= sy_nxt;
      hsync_q <= hsync_nxt;
      vsync_q <= vsync_nxt;
      de_q    <= de_nxt;
      fs_q    <= fs_nxt;
      mode_q  <= mode_nxt;
      ctl_q   <= ctl_nxt;
      ack_q   <= ack_nxt;
      idx_q   <= idx_nxt;
    end
  end

`ifdef HDMI_DATA_ISLAND_EN
  typedef enum logic {DI_IDLE, DI_ARMED} di_state_e;

  localparam int DI_S = H_ACTIVE + 4;
  localparam logic [CORDW-1:0] DI_SAMPLE = CORDW'(H_ACTIVE - 1);
  localparam logic [CORDW-1:0] IPRE_BEG  = CORDW'(DI_S);
  localparam logic [CORDW-1:0] IGL_BEG   = CORDW'(DI_S + 8);
  localparam logic [CORDW-1:0] ISL_BEG   = CORDW'(DI_S + 10);
  localparam logic [CORDW-1:0] IGT_BEG   = CORDW'(DI_S + 10 + 32 * DI_PACKETS);
  localparam logic [CORDW-1:0] DI_END    = CORDW'(DI_S + 12 + 32 * DI_PACKETS);
  localparam logic [CORDW-1:0] DI_LAST   = CORDW'(DI_S + 11 + 32 * DI_PACKETS);

  if ((DI_PACKETS < 1) || (DI_PACKETS > 2)) begin : g_pkt_chk
    $error("hdmi_period_sequencer: DI_PACKETS must be 1 or 2");
  end
  // Island has to finish with at least 12 CTRL pixels left before the video preamble.
  if (DI_S + 12 + 32 * DI_PACKETS > H_TOTAL - 22) begin : g_island_chk
    $error("hdmi_period_sequencer: data island does not fit in horizontal blanking");
  end

  di_state_e di_state, di_state_nxt;

  always_ff @(posedge clk_pix or negedge rst_in) begin
    if (!rst_in) di_state <= DI_IDLE;
    else         di_state <= di_state_nxt;
  end

  always_comb begin
    di_state_nxt = di_state;
    case (di_state)
      DI_IDLE:  if (run && (sx == DI_SAMPLE) && bus.pkt_req) di_state_nxt = DI_ARMED;
      DI_ARMED: if (sx == DI_LAST) di_state_nxt = DI_IDLE;
      default:  di_state_nxt = DI_IDLE;
    endcase
  end

  always_comb begin
    di_mode = M_CTRL;
    di_idx  = '0;
    if ((di_state_nxt == DI_ARMED) && (sx_nxt >= IPRE_BEG)) begin
      if (sx_nxt < IGL_BEG) begin
        di_mode = M_IPRE;
      end else if (sx_nxt < ISL_BEG) begin
        di_mode = M_IGUARD;
      end else if (sx_nxt < IGT_BEG) begin
        di_mode = M_ISLAND;
        di_idx  = 5'(sx_nxt - ISL_BEG);
      end else if (sx_nxt < DI_END) begin
        di_mode = M_IGUARD;
      end
    end
  end
`else
  logic unused_pkt_req;
  assign unused_pkt_req = bus.pkt_req;
  assign di_mode        = M_CTRL;
  assign di_idx         = '0;
`endif

  assign bus.sx          = sx;
  assign bus.sy          = sy;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.frame_start = fs_q;
  assign bus.mode        = mode_q;
  assign bus.ctl         = ctl_q;
  assign bus.pkt_ack     = ack_q;
  assign bus.pkt_idx     = idx_q;

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Directed bench for hdmi_period_sequencer: 640x480 default, a small 64x12 raster, and 720p
// with positive syncs, all sharing clock and reset.
module tb_hdmi_period_sequencer;

`ifdef HDMI_DATA_ISLAND_EN
  localparam bit DI_ON = 1'b1;
`else
  localparam bit DI_ON = 1'b0;
`endif

  typedef struct {
    int       dut;
    int       cyc;
    int       sx;
    int       sy;
    bit       hs;
    bit       vs;
    bit       de;
    bit [2:0] mode;
    bit [3:0] ctl;
    bit       fs;
  } vec_t;

  logic clk_pix = 1'b0;
  logic rst_in  = 1'b0;
  int   cyc     = -1;
  int   checks  = 0;
  int   fails   = 0;
  bit   mon_on  = 1'b0;
  int   n_de = 0, n_fs = 0, n_hs = 0, n_vs = 0;
  vec_t vq[$];

  always #5 clk_pix = ~clk_pix;

  hdmi_period_sequencer_if #(.CORDW(12)) bus_a ();
  hdmi_period_sequencer_if #(.CORDW(12)) bus_b ();
  hdmi_period_sequencer_if #(.CORDW(12)) bus_c ();

  hdmi_period_sequencer u_dut_a (.clk_pix(clk_pix), .rst_in(rst_in), .bus(bus_a));

  hdmi_period_sequencer #(
    .H_ACTIVE(64), .H_FP(16), .H_SYNC(24), .H_BP(40),
    .V_ACTIVE(12), .V_FP(2),  .V_SYNC(2),  .V_BP(4),
    .DI_PACKETS(1)
  ) u_dut_b (.clk_pix(clk_pix), .rst_in(rst_in), .bus(bus_b));

  hdmi_period_sequencer #(
    .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_ACTIVE(720),  .V_FP(5),   .V_SYNC(5),  .V_BP(20),
    .H_POL(1), .V_POL(1)
  ) u_dut_c (.clk_pix(clk_pix), .rst_in(rst_in), .bus(bus_c));

  // Cycle index since reset release: cycle n shows raster pixel n.
  always @(posedge clk_pix or negedge rst_in) begin
    if (!rst_in) cyc <= -1;
    else         cyc <= cyc + 1;
  end

  always @(negedge clk_pix) begin
    if (mon_on && (cyc >= 0) && (cyc < 5760)) begin
      if (bus_b.de)          n_de <= n_de + 1;
      if (bus_b.frame_start) n_fs <= n_fs + 1;
      if (!bus_b.hsync)      n_hs <= n_hs + 1;
      if (!bus_b.vsync)      n_vs <= n_vs + 1;
    end
  end

  assign bus_a.pkt_req = 1'b0;
  assign bus_c.pkt_req = 1'b0;
  logic pkt_req_b = 1'b0;
  assign bus_b.pkt_req = pkt_req_b;

  function automatic logic [34:0] obs(input int d);
    case (d)
      0:       return {bus_a.sx, bus_a.sy, bus_a.hsync, bus_a.vsync, bus_a.de, bus_a.mode,
                       bus_a.ctl, bus_a.frame_start};
      1:       return {bus_b.sx, bus_b.sy, bus_b.hsync, bus_b.vsync, bus_b.de, bus_b.mode,
                       bus_b.ctl, bus_b.frame_start};
      default: return {bus_c.sx, bus_c.sy, bus_c.hsync, bus_c.vsync, bus_c.de, bus_c.mode,
                       bus_c.ctl, bus_c.frame_start};
    endcase
  endfunction

  function automatic logic [34:0] pack(input int x, input int y, input bit hs, input bit vs,
                                       input bit de, input bit [2:0] m, input bit [3:0] c,
                                       input bit fs);
    return {12'(x), 12'(y), hs, vs, de, m, c, fs};
  endfunction

  // Island-window expectation for the small raster: IPRE 68..75, IGUARD 76..77,
  // ISLAND 78..109, IGUARD 110..111, all other blank pixels CTRL.
  function automatic logic [12:0] di_exp(input int x);
    logic [2:0] m  = 3'd0;
    logic [3:0] c  = 4'd0;
    logic       a  = 1'b0;
    logic [4:0] ix = 5'd0;
    if (DI_ON) begin
      if (x >= 68 && x <= 75) begin
        m = 3'd6;
        c = 4'b0101;
      end else if (x >= 76 && x <= 77) begin
        m = 3'd4;
      end else if (x >= 78 && x <= 109) begin
        m  = 3'd3;
        ix = 5'(x - 78);
        a  = (x == 78);
      end else if (x >= 110 && x <= 111) begin
        m = 3'd4;
      end
    end
    return {m, c, a, ix};
  endfunction

  function automatic logic [12:0] di_obs();
    return {bus_b.mode, bus_b.ctl, bus_b.pkt_ack, bus_b.pkt_idx};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic goto(input int c);
    int guard = 0;
    while (cyc != c && guard < 20000) begin
      @(negedge clk_pix);
      guard++;
    end
    if (cyc != c) begin
      checks++;
      fails++;
      $display("FAIL goto: cycle %0d reached, wanted %0d", cyc, c);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rst a"}, obs(0), pack(0, 0, 1, 1, 0, 0, 0, 0));
    chk({tag, " rst b"}, obs(1), pack(0, 0, 1, 1, 0, 0, 0, 0));
    chk({tag, " rst c"}, obs(2), pack(0, 0, 0, 0, 0, 0, 0, 0));
    chk({tag, " rst b pkt"}, {bus_b.pkt_ack, bus_b.pkt_idx}, 6'd0);
  endtask

  task automatic add(input int d, input int c, input int x, input int y, input bit hs,
                     input bit vs, input bit de, input bit [2:0] m, input bit [3:0] ct,
                     input bit fs);
    vq.push_back('{d, c, x, y, hs, vs, de, m, ct, fs});
  endtask

  initial begin
    int base;
    // dut cyc sx sy hs vs de mode ctl fs   (sorted by cycle)
    add(0,    0,    0,  0, 1, 1, 1, 1, 4'b0000, 1);
    add(1,    0,    0,  0, 1, 1, 1, 1, 4'b0000, 1);
    add(2,    0,    0,  0, 0, 0, 1, 1, 4'b0000, 1);
    add(1,   63,   63,  0, 1, 1, 1, 1, 4'b0000, 0);
    add(1,   64,   64,  0, 1, 1, 0, 0, 4'b0000, 0);
    add(1,   80,   80,  0, 0, 1, 0, 0, 4'b0000, 0);
    add(1,  103,  103,  0, 0, 1, 0, 0, 4'b0000, 0);
    add(1,  104,  104,  0, 1, 1, 0, 0, 4'b0000, 0);
    add(1,  134,  134,  0, 1, 1, 0, 5, 4'b0001, 0);
    add(1,  143,  143,  0, 1, 1, 0, 2, 4'b0000, 0);
    add(0,  639,  639,  0, 1, 1, 1, 1, 4'b0000, 0);
    add(0,  640,  640,  0, 1, 1, 0, 0, 4'b0000, 0);
    add(0,  655,  655,  0, 1, 1, 0, 0, 4'b0000, 0);
    add(0,  656,  656,  0, 0, 1, 0, 0, 4'b0000, 0);
    add(0,  751,  751,  0, 0, 1, 0, 0, 4'b0000, 0);
    add(0,  752,  752,  0, 1, 1, 0, 0, 4'b0000, 0);
    add(0,  789,  789,  0, 1, 1, 0, 0, 4'b0000, 0);
    add(0,  790,  790,  0, 1, 1, 0, 5, 4'b0001, 0);
    add(0,  797,  797,  0, 1, 1, 0, 5, 4'b0001, 0);
    add(0,  798,  798,  0, 1, 1, 0, 2, 4'b0000, 0);
    add(0,  799,  799,  0, 1, 1, 0, 2, 4'b0000, 0);
    add(0,  800,    0,  1, 1, 1, 1, 1, 4'b0000, 0);
    add(2, 1279, 1279,  0, 0, 0, 1, 1, 4'b0000, 0);
    add(2, 1280, 1280,  0, 0, 0, 0, 0, 4'b0000, 0);
    add(2, 1389, 1389,  0, 0, 0, 0, 0, 4'b0000, 0);
    add(2, 1390, 1390,  0, 1, 0, 0, 0, 4'b0000, 0);
    add(2, 1429, 1429,  0, 1, 0, 0, 0, 4'b0000, 0);
    add(2, 1430, 1430,  0, 0, 0, 0, 0, 4'b0000, 0);
    add(1, 1574,  134, 10, 1, 1, 0, 5, 4'b0001, 0);
    add(1, 1584,    0, 11, 1, 1, 1, 1, 4'b0000, 0);
    add(2, 1640, 1640,  0, 0, 0, 0, 5, 4'b0001, 0);
    add(2, 1649, 1649,  0, 0, 0, 0, 2, 4'b0000, 0);
    add(2, 1650,    0,  1, 0, 0, 1, 1, 4'b0000, 0);
    add(1, 1718,  134, 11, 1, 1, 0, 0, 4'b0000, 0);
    add(1, 1727,  143, 11, 1, 1, 0, 0, 4'b0000, 0);
    add(1, 1728,    0, 12, 1, 1, 0, 0, 4'b0000, 0);
    add(1, 2016,    0, 14, 1, 0, 0, 0, 4'b0000, 0);
    add(1, 2303,  143, 15, 1, 0, 0, 0, 4'b0000, 0);
    add(1, 2304,    0, 16, 1, 1, 0, 0, 4'b0000, 0);
    add(1, 2869,  133, 19, 1, 1, 0, 0, 4'b0000, 0);
    add(1, 2870,  134, 19, 1, 1, 0, 5, 4'b0001, 0);
    add(1, 2877,  141, 19, 1, 1, 0, 5, 4'b0001, 0);
    add(1, 2878,  142, 19, 1, 1, 0, 2, 4'b0000, 0);
    add(1, 2880,    0,  0, 1, 1, 1, 1, 4'b0000, 1);
    add(1, 2881,    1,  0, 1, 1, 1, 1, 4'b0000, 0);
    add(1, 5759,  143, 19, 1, 1, 0, 2, 4'b0000, 0);
    add(1, 5760,    0,  0, 1, 1, 1, 1, 4'b0000, 1);

    repeat (3) @(negedge clk_pix);
    chk_reset("power-on");
    rst_in = 1'b1;
    mon_on = 1'b1;

    foreach (vq[i]) begin
      goto(vq[i].cyc);
      chk($sformatf("vec%0d dut%0d cyc%0d", i, vq[i].dut, vq[i].cyc), obs(vq[i].dut),
          pack(vq[i].sx, vq[i].sy, vq[i].hs, vq[i].vs, vq[i].de, vq[i].mode, vq[i].ctl,
               vq[i].fs));
    end

    mon_on = 1'b0;
    chk("b de count 2 frames", n_de, 1536);
    chk("b frame_start count", n_fs, 2);
    chk("b hsync low count", n_hs, 960);
    chk("b vsync low count", n_vs, 576);

    // Line with pkt_req high only across the sample pixel (sx 63).
    base = ((cyc / 144) + 1) * 144;
    goto(base + 62);
    pkt_req_b = 1'b1;
    for (int x = 64; x <= 113; x++) begin
      goto(base + x);
      if (x == 64) pkt_req_b = 1'b0;
      chk($sformatf("island sx%0d", x), di_obs(), di_exp(x));
    end

    // pkt_req rises one pixel after the sample point: no island on this line.
    base = base + 144;
    goto(base + 64);
    pkt_req_b = 1'b1;
    for (int x = 64; x <= 133; x++) begin
      goto(base + x);
      if (x == 100) pkt_req_b = 1'b0;
      chk($sformatf("late req sx%0d", x), di_obs(), 13'd0);
    end

    // Reset in the middle of a running island.
    base = base + 144;
    goto(base + 62);
    pkt_req_b = 1'b1;
    goto(base + 64);
    pkt_req_b = 1'b0;
    goto(base + 90);
    chk("pre-reset b sx90", di_obs(), di_exp(90));
    rst_in = 1'b0;
    #1;
    chk_reset("async");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_pix);
      chk_reset($sformatf("hold%0d", k));
    end
    rst_in = 1'b1;
    goto(0);
    chk("release a", obs(0), pack(0, 0, 1, 1, 1, 1, 4'b0000, 1));
    chk("release b", obs(1), pack(0, 0, 1, 1, 1, 1, 4'b0000, 1));
    chk("release c", obs(2), pack(0, 0, 0, 0, 1, 1, 4'b0000, 1));
    goto(1);
    chk("release a+1", obs(0), pack(1, 0, 1, 1, 1, 1, 4'b0000, 0));
    goto(78);
    chk("island aborted b sx78", di_obs(), 13'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
